// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, latched
// request record and the default timeout.
package dmem_arb_pkg;

    // Default number of memory wait cycles before an access is abandoned.
    localparam int unsigned TimeoutDefault = 15;

    // Wait counter width; covers the full 1..255 timeout range.
    localparam int unsigned WaitCntW = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } arb_state_e;

    // Request fields captured at grant and replayed to memory.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  be;
        logic        wren;
    } dmem_req_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-input round-robin grant. The pointer remembers the last winner so a
// tie goes to the other master; after reset m0 wins the first tie.
module arb_rr2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] gnt
);

    // Index of the master granted most recently.
    logic last_q;
    logic last_d;

    // Grant decode: a lone requester wins, a tie goes to the non-last master.
    always_comb begin
        gnt = 2'b00;
        unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Pointer moves only when a grant is actually taken.
    always_comb begin
        last_d = last_q;
        if (grant_en && (gnt != 2'b00)) begin
            last_d = gnt[1];
        end
    end

    // Pointer register; reset value makes m0 win the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between the core (m0) and the loader/debug
// master (m1). One access at a time: IDLE -> ACCESS -> RESP -> IDLE.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = TimeoutDefault
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_din,
    input  logic [3:0]  m0_be,
    input  logic        m0_wren,
    output logic        m0_ack,
    output logic [31:0] m0_dout,

    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_din,
    input  logic [3:0]  m1_be,
    input  logic        m1_wren,
    output logic        m1_ack,
    output logic [31:0] m1_dout,

    output logic        err,

    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_din,
    output logic [3:0]  dmem_be,
    output logic        dmem_wren,
    output logic        dmem_en,
    input  logic [31:0] dmem_dout,
    input  logic        dmem_ready
);

    localparam logic [WaitCntW-1:0] TimeoutCnt = WaitCntW'(TIMEOUT);

    arb_state_e          state_q;
    arb_state_e          state_d;
    dmem_req_t           req_q;
    dmem_req_t           win_req;
    logic                owner_q;
    logic [WaitCntW-1:0] wait_q;
    logic [WaitCntW-1:0] wait_inc;
    logic                err_q;
    logic [31:0]         m0_dout_q;
    logic [31:0]         m1_dout_q;
    logic [1:0]          gnt;
    logic                idle;
    logic                grant;
    logic                in_access;
    logic                timeout;
    logic                access_done;
    logic [31:0]         rdata;

    assign idle      = (state_q == StIdle);
    assign in_access = (state_q == StAccess);
    assign grant     = idle && (gnt != 2'b00);
    assign wait_inc  = wait_q + WaitCntW'(1);

    // The wait that would reach the limit ends the access with an error.
    assign timeout     = in_access && !dmem_ready && (wait_inc == TimeoutCnt);
    assign access_done = in_access && (dmem_ready || timeout);
    assign rdata       = dmem_ready ? dmem_dout : 32'h0;

    arb_rr2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req      ({m1_req, m0_req}),
        .grant_en (idle),
        .gnt      (gnt)
    );

    // Select the winning master's request fields for latching.
    always_comb begin
        if (gnt[1]) begin
            win_req.addr = m1_addr;
            win_req.din  = m1_din;
            win_req.be   = m1_be;
            win_req.wren = m1_wren;
        end else begin
            win_req.addr = m0_addr;
            win_req.din  = m0_din;
            win_req.be   = m0_be;
            win_req.wren = m0_wren;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                if (access_done) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs: memory strobes only in ACCESS, ack/err only in RESP.
    always_comb begin
        dmem_en   = in_access;
        dmem_wren = in_access && req_q.wren;
        dmem_addr = req_q.addr;
        dmem_din  = req_q.din;
        dmem_be   = req_q.be;
        m0_ack    = (state_q == StResp) && !owner_q;
        m1_ack    = (state_q == StResp) && owner_q;
        err       = (state_q == StResp) && err_q;
        m0_dout   = m0_dout_q;
        m1_dout   = m1_dout_q;
    end

    // Capture the winner's request and identity at grant only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q   <= '0;
            owner_q <= 1'b0;
        end else if (grant) begin
            req_q   <= win_req;
            owner_q <= gnt[1];
        end
    end

    // Wait counter: counts not-ready ACCESS cycles, cleared when the access ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else if (access_done) begin
            wait_q <= '0;
        end else if (in_access) begin
            wait_q <= wait_inc;
        end
    end

    // Response: error flag and per-master read data, updated as the access ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q     <= 1'b0;
            m0_dout_q <= 32'h0;
            m1_dout_q <= 32'h0;
        end else if (access_done) begin
            err_q <= timeout;
            // Writes leave the owner's read data untouched.
            if (!req_q.wren) begin
                if (owner_q) begin
                    m1_dout_q <= rdata;
                end else begin
                    m0_dout_q <= rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: table of single accesses, directed
// multi-cycle sequences, then randomized traffic against a transaction model.
module tb_dmem_arbiter;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m0_wren, m0_ack;
    logic [31:0] m0_addr, m0_din, m0_dout;
    logic [3:0]  m0_be;
    logic        m1_req, m1_wren, m1_ack;
    logic [31:0] m1_addr, m1_din, m1_dout;
    logic [3:0]  m1_be;
    logic        err;
    logic [31:0] dmem_addr, dmem_din, dmem_dout;
    logic [3:0]  dmem_be;
    logic        dmem_wren, dmem_en, dmem_ready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .m0_req     (m0_req),
        .m0_addr    (m0_addr),
        .m0_din     (m0_din),
        .m0_be      (m0_be),
        .m0_wren    (m0_wren),
        .m0_ack     (m0_ack),
        .m0_dout    (m0_dout),
        .m1_req     (m1_req),
        .m1_addr    (m1_addr),
        .m1_din     (m1_din),
        .m1_be      (m1_be),
        .m1_wren    (m1_wren),
        .m1_ack     (m1_ack),
        .m1_dout    (m1_dout),
        .err        (err),
        .dmem_addr  (dmem_addr),
        .dmem_din   (dmem_din),
        .dmem_be    (dmem_be),
        .dmem_wren  (dmem_wren),
        .dmem_en    (dmem_en),
        .dmem_dout  (dmem_dout),
        .dmem_ready (dmem_ready)
    );

    typedef struct {
        bit          mst;
        logic        wren;
        logic [31:0] addr;
        logic [31:0] din;
        logic [3:0]  be;
        int          delay;       // not-ready cycles before ready; >= TMO never completes
        logic [31:0] mem_data;
        logic        exp_err;
        logic [31:0] exp_dout;
        int          exp_en_cycles;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_master(input bit m, input logic r, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] b, input logic w);
        if (!m) begin
            m0_req = r; m0_addr = a; m0_din = d; m0_be = b; m0_wren = w;
        end else begin
            m1_req = r; m1_addr = a; m1_din = d; m1_be = b; m1_wren = w;
        end
    endtask

    task automatic idle_inputs();
        set_master(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        set_master(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        dmem_ready = 1'b0;
        dmem_dout  = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic bit rr_pick(input logic [1:0] r, input bit last_g);
        if (r == 2'b01) return 1'b0;
        if (r == 2'b10) return 1'b1;
        return ~last_g;
    endfunction

    // One access by one master; optionally rewrites its request after grant.
    task automatic run_single(input vec_t v, input bit mutate);
        int   en_cnt  = 0;
        int   ack_cnt = 0;
        int   ack_cyc = -1;
        logic ack, oack;
        set_master(v.mst, 1'b1, v.addr, v.din, v.be, v.wren);
        dmem_ready = 1'b0;
        dmem_dout  = v.mem_data;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            ack  = v.mst ? m1_ack : m0_ack;
            oack = v.mst ? m0_ack : m1_ack;
            check("other ack", 32'(oack), 32'h0);
            check("wren without en", 32'(dmem_wren & ~dmem_en), 32'h0);
            if (dmem_en) begin
                check("mem addr", dmem_addr, v.addr);
                check("mem wren", 32'(dmem_wren), 32'(v.wren));
                if (v.wren) begin
                    check("mem din", dmem_din, v.din);
                    check("mem be", 32'(dmem_be), 32'(v.be));
                end
                if (mutate && en_cnt == 0) begin
                    set_master(v.mst, 1'b1, 32'h80, ~v.din, ~v.be, ~v.wren);
                end
                dmem_ready = (en_cnt == v.delay);
                en_cnt++;
            end else begin
                dmem_ready = 1'b0;
            end
            if (ack) begin
                ack_cnt++;
                ack_cyc = cyc;
                check("ack err", 32'(err), 32'(v.exp_err));
                check("ack dout", v.mst ? m1_dout : m0_dout, v.exp_dout);
                set_master(v.mst, 1'b0, v.addr, v.din, v.be, v.wren);
            end else begin
                check("err without ack", 32'(err), 32'h0);
            end
            if (ack_cnt > 0 && cyc >= ack_cyc + 2) break;
        end
        check("en cycles", en_cnt, v.exp_en_cycles);
        check("ack count", ack_cnt, 1);
        check("ack latency", ack_cyc, v.exp_en_cycles + 1);
        dmem_ready = 1'b0;
    endtask

    // Both masters request continuously: grants alternate m0, m1, m0 every 3 cycles.
    task automatic tie_test();
        int grants    = 0;
        int last_rise = -1;
        bit prev_en   = 1'b0;
        bit exp_seq [3] = '{1'b0, 1'b1, 1'b0};
        set_master(1'b0, 1'b1, 32'h100, 32'h0, 4'hF, 1'b0);
        set_master(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF, 1'b1);
        dmem_ready = 1'b1;
        dmem_dout  = 32'h77;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (dmem_en && !prev_en) begin
                if (grants < 3) begin
                    check("tie grant", dmem_addr, exp_seq[grants] ? 32'h200 : 32'h100);
                    if (exp_seq[grants]) begin
                        check("tie m1 wren", 32'(dmem_wren), 32'h1);
                        check("tie m1 din", dmem_din, 32'hDEAD_BEEF);
                        check("tie m1 be", 32'(dmem_be), 32'hF);
                    end
                    if (grants > 0) check("b2b spacing", cyc - last_rise, 3);
                end
                grants++;
                last_rise = cyc;
                if (grants == 3) begin
                    m0_req = 1'b0;
                    m1_req = 1'b0;
                end
            end
            prev_en = dmem_en;
        end
        check("tie grant count", grants, 3);
        dmem_ready = 1'b0;
    endtask

    // Reset mid-access after m0 won last: no ack, and the next tie still goes to m0.
    task automatic reset_test();
        vec_t v;
        v = '{mst: 1'b1, wren: 1'b0, addr: 32'h20, din: 32'h0, be: 4'hF, delay: 0,
              mem_data: 32'h1, exp_err: 1'b0, exp_dout: 32'h1, exp_en_cycles: 1};
        run_single(v, 1'b0);
        set_master(1'b0, 1'b1, 32'h300, 32'h0, 4'hF, 1'b0);
        dmem_ready = 1'b0;
        for (int i = 0; i < 5 && !dmem_en; i++) @(negedge clk);
        check("rst pre en", 32'(dmem_en), 32'h1);
        check("rst pre addr", dmem_addr, 32'h300);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst en", 32'(dmem_en), 32'h0);
        check("rst wren", 32'(dmem_wren), 32'h0);
        check("rst acks", 32'({m1_ack, m0_ack, err}), 32'h0);
        check("rst addr", dmem_addr, 32'h0);
        check("rst douts", m0_dout | m1_dout, 32'h0);
        m0_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post rst quiet", 32'({dmem_en, m1_ack, m0_ack}), 32'h0);
        end
        set_master(1'b0, 1'b1, 32'h400, 32'h0, 4'hF, 1'b0);
        set_master(1'b1, 1'b1, 32'h500, 32'h0, 4'hF, 1'b0);
        dmem_ready = 1'b1;
        for (int i = 0; i < 5 && !dmem_en; i++) @(negedge clk);
        check("post rst tie en", 32'(dmem_en), 32'h1);
        check("post rst tie winner", dmem_addr, 32'h400);
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (3) @(negedge clk);
        dmem_ready = 1'b0;
    endtask

    // Random traffic checked against a transaction-level model of the arbiter.
    task automatic random_phase(input int ncyc);
        int          mode = 0;   // 0: idle, 1: access, 2: response
        int          obs;
        bit          last = 1'b1;
        bit          own = 1'b0;
        bit          exp_err = 1'b0;
        logic [31:0] exp_dout = 32'h0;
        logic [31:0] hold [2] = '{32'h0, 32'h0};
        logic        r_req [2] = '{1'b0, 1'b0};
        logic [31:0] r_addr [2], r_din [2];
        logic [3:0]  r_be [2];
        logic        r_wren [2];
        logic [31:0] a_addr = 32'h0, a_din = 32'h0;
        logic [3:0]  a_be = 4'h0;
        logic        a_wren = 1'b0;
        int          k = 0;
        int          delay = 0;
        bit          acked [2];
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            obs   = mode;
            acked = '{1'b0, 1'b0};
            check("rnd wren without en", 32'(dmem_wren & ~dmem_en), 32'h0);
            if (obs == 0) begin
                check("rnd idle quiet", 32'({dmem_en, err, m1_ack, m0_ack}), 32'h0);
            end else if (obs == 1) begin
                check("rnd access en", 32'(dmem_en), 32'h1);
                check("rnd access addr", dmem_addr, a_addr);
                check("rnd access wr", {dmem_din[27:0], dmem_be}, {a_din[27:0], a_be});
                check("rnd access wren", 32'(dmem_wren), 32'(a_wren));
                check("rnd access quiet", 32'({err, m1_ack, m0_ack}), 32'h0);
            end else begin
                check("rnd ack owner", 32'({dmem_en, m1_ack, m0_ack}),
                      own ? 32'h2 : 32'h1);
                check("rnd err", 32'(err), 32'(exp_err));
                if (!a_wren) hold[own] = exp_dout;
                acked[own] = 1'b1;
            end
            check("rnd m0_dout", m0_dout, hold[0]);
            check("rnd m1_dout", m1_dout, hold[1]);

            dmem_dout = $urandom;
            if (obs == 1) begin
                if (k == delay) begin
                    dmem_ready = 1'b1;
                    exp_err    = 1'b0;
                    exp_dout   = dmem_dout;
                    mode       = 2;
                end else if (k == TMO - 1) begin
                    dmem_ready = 1'b0;
                    exp_err    = 1'b1;
                    exp_dout   = 32'h0;
                    mode       = 2;
                end else begin
                    dmem_ready = 1'b0;
                    k++;
                end
            end else begin
                dmem_ready = 1'($urandom_range(0, 1));
                if (obs == 2) mode = 0;
            end

            for (int i = 0; i < 2; i++) begin
                if (acked[i] || !r_req[i]) begin
                    r_req[i] = acked[i] ? 1'($urandom_range(0, 1))
                                        : ($urandom_range(0, 3) == 0);
                    r_addr[i] = $urandom;
                    r_din[i]  = $urandom;
                    r_be[i]   = 4'($urandom_range(0, 15));
                    r_wren[i] = 1'($urandom_range(0, 1));
                end else if ($urandom_range(0, 7) == 0) begin
                    r_addr[i] = $urandom;
                    r_din[i]  = $urandom;
                    r_be[i]   = 4'($urandom_range(0, 15));
                    r_wren[i] = 1'($urandom_range(0, 1));
                end
                set_master(i[0], r_req[i], r_addr[i], r_din[i], r_be[i], r_wren[i]);
            end

            if (obs == 0 && (r_req[0] || r_req[1])) begin
                own    = rr_pick({r_req[1], r_req[0]}, last);
                last   = own;
                a_addr = r_addr[own];
                a_din  = r_din[own];
                a_be   = r_be[own];
                a_wren = r_wren[own];
                k      = 0;
                if (a_wren || $urandom_range(0, 7) != 0) delay = $urandom_range(0, 6);
                else delay = $urandom_range(TMO - 1, TMO + 4);
                mode = 1;
            end
        end
        idle_inputs();
    endtask

    initial begin
        vec_t tbl [6];
        vec_t v;
        tbl[0] = '{mst: 1'b0, wren: 1'b0, addr: 32'h10, din: 32'h0, be: 4'hF, delay: 0,
                   mem_data: 32'h1234_5678, exp_err: 1'b0, exp_dout: 32'h1234_5678,
                   exp_en_cycles: 1};
        tbl[1] = '{mst: 1'b1, wren: 1'b0, addr: 32'h20, din: 32'h0, be: 4'hF, delay: 4,
                   mem_data: 32'hCAFE_F00D, exp_err: 1'b0, exp_dout: 32'hCAFE_F00D,
                   exp_en_cycles: 5};
        tbl[2] = '{mst: 1'b0, wren: 1'b0, addr: 32'h30, din: 32'h0, be: 4'hF, delay: 99,
                   mem_data: 32'hAAAA_AAAA, exp_err: 1'b1, exp_dout: 32'h0,
                   exp_en_cycles: TMO};
        tbl[3] = '{mst: 1'b1, wren: 1'b1, addr: 32'h44, din: 32'h1122_3344, be: 4'h3,
                   delay: 2, mem_data: 32'h5555_5555, exp_err: 1'b0,
                   exp_dout: 32'hCAFE_F00D, exp_en_cycles: 3};
        tbl[4] = '{mst: 1'b0, wren: 1'b0, addr: 32'h50, din: 32'h0, be: 4'hF,
                   delay: TMO - 1, mem_data: 32'h0BAD_F00D, exp_err: 1'b0,
                   exp_dout: 32'h0BAD_F00D, exp_en_cycles: TMO};
        tbl[5] = '{mst: 1'b1, wren: 1'b0, addr: 32'h60, din: 32'h0, be: 4'hF, delay: TMO,
                   mem_data: 32'h6666_6666, exp_err: 1'b1, exp_dout: 32'h0,
                   exp_en_cycles: TMO};

        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        check("reset en", 32'(dmem_en), 32'h0);
        check("reset wren", 32'(dmem_wren), 32'h0);
        check("reset acks", 32'({m1_ack, m0_ack, err}), 32'h0);
        check("reset mem outs", dmem_addr | dmem_din | 32'(dmem_be), 32'h0);
        check("reset douts", m0_dout | m1_dout, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_single(tbl[i], 1'b0);

        v = '{mst: 1'b1, wren: 1'b0, addr: 32'h40, din: 32'h1111, be: 4'hF, delay: 3,
              mem_data: 32'h4040_4040, exp_err: 1'b0, exp_dout: 32'h4040_4040,
              exp_en_cycles: 4};
        run_single(v, 1'b1);

        tie_test();
        reset_test();
        random_phase(3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: max memory wait cycles per access before error completion (1..255).
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  asynchronous, active-high reset.
REQ-004 Port m0_req  input  1  core data request; held high until m0_ack.
REQ-005 Port m0_addr  input  32  core byte address.
REQ-006 Port m0_din  input  32  core write data.
REQ-007 Port m0_be  input  4  core byte enables.
REQ-008 Port m0_wren  input  1  core write (1) / read (0).
REQ-009 Port m0_ack  output  1  one-cycle completion pulse to core.
REQ-010 Port m0_dout  output  32  core read data, valid with m0_ack.
REQ-011 Port m1_req, m1_addr, m1_din, m1_be, m1_wren, m1_ack, m1_dout: same directions, widths and meanings for the loader/debug master.
REQ-012 Port err  output  1  high with the ack pulse when the access timed out.
REQ-013 Port dmem_addr  output  32  memory address.
REQ-014 Port dmem_din  output  32  memory write data.
REQ-015 Port dmem_be  output  4  memory byte enables.
REQ-016 Port dmem_wren  output  1  memory write strobe.
REQ-017 Port dmem_en  output  1  memory access valid.
REQ-018 Port dmem_dout  input  32  memory read data.
REQ-019 Port dmem_ready  input  1  memory completes the current access this cycle.

Function
REQ-020 FSM states: IDLE, ACCESS, RESP.
REQ-021 IDLE: if any req is high, latch the winner's addr/din/be/wren into internal registers and go to ACCESS next cycle; else stay.
REQ-022 Arbitration is round-robin: one requester wins alone; if both request, the master not granted last wins; the pointer updates at grant.
REQ-023 ACCESS: dmem_en=1, dmem_addr/din/be/wren driven from latched registers, stable every cycle until exit.
REQ-024 ACCESS with dmem_ready=1: capture dmem_dout (reads), clear wait counter, go to RESP.
REQ-025 ACCESS: wait counter increments each cycle dmem_ready=0; when it reaches TIMEOUT, go to RESP with err flag set and read data forced to 0.
REQ-026 RESP: assert owner's ack for exactly one cycle with dout and err; go to IDLE; non-owner ack stays 0.
REQ-027 Minimum latency with dmem_ready tied high: req sampled in cycle N, ack in cycle N+2; max back-to-back rate is one access per 3 cycles.
REQ-028 Outside ACCESS: dmem_en=0, dmem_wren=0, other memory outputs hold latched values.
REQ-029 Request fields are sampled only at grant; changes or req deassertion after grant do not affect the access in flight.
REQ-030 A request arriving during ACCESS/RESP waits; it is arbitrated at the next IDLE.
REQ-031 m0_dout/m1_dout hold their last value between acks; err is 0 whenever no ack is high.
REQ-032 dmem_wren never asserts without dmem_en.

Reset
REQ-033 rst asserted at any time, including mid-ACCESS: state=IDLE, wait counter=0, all acks/err/dmem_en/dmem_wren=0, latched registers and douts=0, round-robin pointer set so m0 wins the first tie.
REQ-034 An access aborted by reset produces no ack; requesters re-issue.

Structure
REQ-035 Shared package dmem_arb_pkg holds the state encoding constants and the TIMEOUT default.
REQ-036 Sub-module arb_rr2 implements the two-input round-robin grant and pointer; the FSM, latches and counter sit in dmem_arbiter.

Verification
REQ-037 m0 read addr 0x0000_0010, dmem_ready=1, dmem_dout=0x1234_5678 -> dmem_en cycle N+1, m0_ack cycle N+2, m0_dout=0x1234_5678, err=0.
REQ-038 m0 and m1 request together three times -> grants m0, m1, m0; m1 write 0xDEAD_BEEF be=0xF produces dmem_wren=1 with that data.
REQ-039 dmem_ready delayed 4 cycles -> dmem_en held 5 cycles with unchanged address; single ack afterward.
REQ-040 dmem_ready held 0, TIMEOUT=15 -> ack with err=1 and dout=0 after 15 wait cycles; FSM returns to IDLE.
REQ-041 rst pulsed during ACCESS -> dmem_en=0 immediately, no ack, next tie granted to m0.
REQ-042 m1 changes addr from 0x40 to 0x80 after grant -> memory sees 0x40 throughout.
